// File: rtl/host_cmd_framer_if.sv
// Command handshake bundle between a host command source and host_cmd_framer.
// One command moves per cycle where CMD_VALID and CMD_READY are both high.
interface host_cmd_framer_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_TYPE;
    logic [7:0] CMD_B0;
    logic [7:0] CMD_B1;
    logic [7:0] CMD_B2;
    logic       PAR_EN;
    logic       PAR_TYP;

    modport master (
        output CMD_VALID, CMD_TYPE, CMD_B0, CMD_B1, CMD_B2,
        output PAR_EN, PAR_TYP,
        input  CMD_READY
    );

    modport slave (
        input  CMD_VALID, CMD_TYPE, CMD_B0, CMD_B1, CMD_B2,
        input  PAR_EN, PAR_TYP,
        output CMD_READY
    );
endinterface

// File: rtl/host_cmd_framer.sv
// Expands one host command into its AA/BB/CC/DD byte sequence and
// serialises it as back-to-back UART frames on SER_OUT.
module host_cmd_framer #(
    parameter int CLKS_PER_BIT = 32,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                CLK,
    input  logic                RST,
    host_cmd_framer_if.slave    cmd,
    output logic                SER_OUT,
    output logic                BUSY,
    output logic                CMD_DONE
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                  state_q;
    logic [7:0]              bit_cnt_q;
    logic [IDX_W-1:0]        bit_idx_q;
    logic [1:0]              byte_idx_q;
    logic [1:0]              type_q;
    logic [DATA_WIDTH-1:0]   b0_q;
    logic [DATA_WIDTH-1:0]   b1_q;
    logic [DATA_WIDTH-1:0]   b2_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    ser_q;
    logic                    done_q;

    logic [DATA_WIDTH-1:0]   cur_byte;
    logic [1:0]              last_idx;
    logic [IDX_W-1:0]        bit_idx_d;
    logic                    cell_end;
    logic                    par_bit;

    // Byte 0 is the protocol header; later bytes are the latched payload.
    always_comb begin
        cur_byte = '0;
        unique case (byte_idx_q)
            2'd0: begin
                unique case (type_q)
                    2'b00: cur_byte = 8'hAA;
                    2'b01: cur_byte = 8'hBB;
                    2'b10: cur_byte = 8'hCC;
                    2'b11: cur_byte = 8'hDD;
                endcase
            end
            2'd1: cur_byte = b0_q;
            2'd2: cur_byte = b1_q;
            2'd3: cur_byte = b2_q;
        endcase
    end

    always_comb begin
        last_idx = 2'd1;
        unique case (type_q)
            2'b00: last_idx = 2'd2;
            2'b01: last_idx = 2'd1;
            2'b10: last_idx = 2'd3;
            2'b11: last_idx = 2'd1;
        endcase
    end

    assign cell_end  = (bit_cnt_q == CNT_MAX);
    assign bit_idx_d = bit_idx_q + IDX_W'(1);
    assign par_bit   = (^cur_byte) ^ par_typ_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            type_q     <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            b2_q       <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            ser_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd.CMD_VALID) begin
                        type_q     <= cmd.CMD_TYPE;
                        b0_q       <= cmd.CMD_B0;
                        b1_q       <= cmd.CMD_B1;
                        b2_q       <= cmd.CMD_B2;
                        par_en_q   <= cmd.PAR_EN;
                        par_typ_q  <= cmd.PAR_TYP;
                        byte_idx_q <= '0;
                        bit_cnt_q  <= '0;
                        ser_q      <= 1'b0;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (cell_end) begin
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                        ser_q     <= cur_byte[0];
                        state_q   <= S_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                    end
                end
                S_DATA: begin
                    if (cell_end) begin
                        bit_cnt_q <= '0;
                        if (bit_idx_q == IDX_MAX) begin
                            bit_idx_q <= '0;
                            if (par_en_q) begin
                                ser_q   <= par_bit;
                                state_q <= S_PARITY;
                            end else begin
                                ser_q   <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_d;
                            ser_q     <= cur_byte[bit_idx_d];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                    end
                end
                S_PARITY: begin
                    if (cell_end) begin
                        bit_cnt_q <= '0;
                        ser_q     <= 1'b1;
                        state_q   <= S_STOP;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                    end
                end
                S_STOP: begin
                    if (cell_end) begin
                        bit_cnt_q <= '0;
                        if (byte_idx_q == last_idx) begin
                            byte_idx_q <= '0;
                            ser_q      <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            ser_q      <= 1'b0;
                            state_q    <= S_START;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd.CMD_READY = (state_q == S_IDLE);
    assign BUSY          = (state_q != S_IDLE);
    assign SER_OUT       = ser_q;
    assign CMD_DONE      = done_q;

endmodule

// File: tb/tb_host_cmd_framer.sv
// Directed bench for host_cmd_framer: expected UART frames go to a queue,
// a line monitor decodes SER_OUT and compares each frame it sees.
module tb_host_cmd_framer;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    logic ser, busy, done;

    host_cmd_framer_if cmd_if();

    host_cmd_framer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
        .CLK      (clk),
        .RST      (rst),
        .cmd      (cmd_if),
        .SER_OUT  (ser),
        .BUSY     (busy),
        .CMD_DONE (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         pe;
        bit         p;
    } frame_t;

    frame_t exp_q[$];
    int vectors = 0;
    int errors  = 0;

    task automatic push(input logic [7:0] d, input bit pe, input bit p);
        frame_t f;
        f.d = d; f.pe = pe; f.p = p;
        exp_q.push_back(f);
    endtask

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Line monitor: samples mid-cell, one comparison per completed frame.
    bit     m_act = 0;
    bit     m_have;
    int     m_cell, m_cnt, m_ncell;
    bit     m_s [11];
    frame_t m_exp;

    always @(negedge clk) begin
        if (rst) begin
            m_act = 0;
        end else begin
            if (!m_act && ser == 1'b0) begin
                m_act  = 1;
                m_cell = 0;
                m_cnt  = 0;
                m_have = (exp_q.size() > 0);
                if (m_have) m_exp = exp_q[0];
                else m_exp.pe = 0;
                m_ncell = m_exp.pe ? 11 : 10;
            end
            if (m_act) begin
                if (m_cnt == 2) m_s[m_cell] = ser;
                m_cnt++;
                if (m_cnt == CPB) begin
                    m_cnt = 0;
                    m_cell++;
                    if (m_cell == m_ncell) begin
                        logic [7:0] got;
                        bit ok;
                        m_act = 0;
                        for (int i = 0; i < 8; i++) got[i] = m_s[i+1];
                        vectors++;
                        ok = m_have && !m_s[0] && m_s[m_ncell-1] &&
                             got == m_exp.d &&
                             (!m_exp.pe || m_s[9] == m_exp.p);
                        if (!ok) begin
                            errors++;
                            $display("FAIL frame: got data %h par %0b start %0b stop %0b, expected %h par %0b (queued %0b)",
                                     got, m_s[9], m_s[0], m_s[m_ncell-1],
                                     m_exp.d, m_exp.p, m_have);
                        end
                        if (m_have) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input logic [1:0] t, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2,
                         input bit pe, input bit pt);
        cmd_if.CMD_TYPE = t;
        cmd_if.CMD_B0   = b0;
        cmd_if.CMD_B1   = b1;
        cmd_if.CMD_B2   = b2;
        cmd_if.PAR_EN   = pe;
        cmd_if.PAR_TYP  = pt;
    endtask

    task automatic send(input logic [1:0] t, input logic [7:0] b0,
                        input logic [7:0] b1, input logic [7:0] b2,
                        input bit pe, input bit pt);
        int n;
        @(posedge clk); #1;
        drive(t, b0, b1, b2, pe, pt);
        cmd_if.CMD_VALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_if.CMD_READY && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            errors++;
            $display("FAIL accept_timeout: got no CMD_READY, expected CMD_READY");
        end
        @(posedge clk); #1;
        cmd_if.CMD_VALID = 1'b0;
    endtask

    // Counts cycles after acceptance until CMD_DONE; optionally fires
    // junk CMD_VALID pulses while the block is busy.
    task automatic wait_done(input bit pulse, output int k,
                             output int nb, output logic s1);
        k = 0; nb = 0; s1 = 1'b1;
        while (k < 1000) begin
            @(negedge clk);
            k++;
            if (k == 1) s1 = ser;
            if (busy) nb++;
            if (done) break;
            if (pulse) begin
                if (k >= 10 && k < 40 && k % 4 == 0) begin
                    drive(2'b00, 8'hEE, 8'hEE, 8'hEE, 1'b0, 1'b0);
                    cmd_if.CMD_VALID = 1'b1;
                end else begin
                    cmd_if.CMD_VALID = 1'b0;
                end
            end
        end
        if (k >= 1000) begin
            errors++;
            $display("FAIL done_timeout: got no CMD_DONE in %0d cycles, expected a pulse", k);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nb;
        logic s1;

        rst = 1'b1;
        cmd_if.CMD_VALID = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ser", ser, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_if.CMD_READY, 1);
        check("rst_done", done, 0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: type 00, no parity
        push(8'hAA, 0, 0); push(8'h05, 0, 0); push(8'h3C, 0, 0);
        send(2'b00, 8'h05, 8'h3C, 8'h00, 1'b0, 1'b0);
        wait_done(0, k, nb, s1);
        check("t1_done_cycle", k, 121);
        check("t1_busy_cycles", nb, 120);
        check("t1_start_bit", s1, 0);
        check("t1_ready_at_done", cmd_if.CMD_READY, 1);

        // 2: type 01, even parity
        push(8'hBB, 1, 0); push(8'h02, 1, 1);
        send(2'b01, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0);
        wait_done(0, k, nb, s1);
        check("t2_done_cycle", k, 89);
        check("t2_busy_cycles", nb, 88);

        // 3: type 10, odd parity
        push(8'hCC, 1, 1); push(8'h0A, 1, 1);
        push(8'h03, 1, 1); push(8'h00, 1, 1);
        send(2'b10, 8'h0A, 8'h03, 8'h00, 1'b1, 1'b1);
        wait_done(0, k, nb, s1);
        check("t3_done_cycle", k, 177);
        check("t3_busy_cycles", nb, 176);

        // 4: CMD_VALID held across two commands
        push(8'hDD, 0, 0); push(8'h01, 0, 0);
        push(8'hBB, 0, 0); push(8'h04, 0, 0);
        @(posedge clk); #1;
        drive(2'b11, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0);
        cmd_if.CMD_VALID = 1'b1;
        @(posedge clk); #1;
        drive(2'b01, 8'h04, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_done(0, k, nb, s1);
        check("t4a_done_cycle", k, 81);
        check("t4a_idle_gap", ser, 1);
        check("t4a_ready_at_done", cmd_if.CMD_READY, 1);
        @(posedge clk); #1;
        cmd_if.CMD_VALID = 1'b0;
        wait_done(1, k, nb, s1);
        check("t4b_start_after_gap", s1, 0);
        check("t4b_done_cycle", k, 81);
        cmd_if.CMD_VALID = 1'b0;
        @(negedge clk);
        check("t4b_no_queued_busy", busy, 0);

        // 5: reset mid data bit of byte 2
        push(8'hAA, 0, 0);
        send(2'b00, 8'h05, 8'h3C, 8'h00, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t5_ser", ser, 1);
        check("t5_busy", busy, 0);
        check("t5_ready", cmd_if.CMD_READY, 1);
        check("t5_done", done, 0);
        push(8'hCC, 0, 0); push(8'h11, 0, 0);
        push(8'h22, 0, 0); push(8'h33, 0, 0);
        send(2'b10, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0);
        wait_done(0, k, nb, s1);
        check("t5_new_done_cycle", k, 161);

        // 6: inputs change right after acceptance
        push(8'hAA, 1, 0); push(8'h81, 1, 0); push(8'h7E, 1, 0);
        send(2'b00, 8'h81, 8'h7E, 8'h00, 1'b1, 1'b0);
        drive(2'b11, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1);
        wait_done(0, k, nb, s1);
        check("t6_done_cycle", k, 133);

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
